countdown_arbiter: RTL and testbench

Parametrised multi-channel countdown timer with single-digit seven-segment output. A start edge launches a countdown from `COUNT_FROM` seconds. The first of `CH` finish buttons pressed before expiry wins: the block raises `flag` and latches the winner's index. If no button is pressed in time, the display shows "E". The block sits between the debounced button inputs and one seven-segment digit on the board, and is the multi-player, configurable-duration successor of the single-channel 5-second timer.

---
 rtl/countdown_arbiter.sv | 145 ++++++++++++++
 tb/tb_countdown_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_arbiter.sv
// countdown_arbiter: multi-channel countdown timer driving one seven-segment
// digit. A rising edge on start counts down from COUNT_FROM seconds; the first
// finish channel pressed before expiry wins (flag + winner). Otherwise the
// digit shows "E" once the countdown runs out.
//
// Optional build macro: COUNTDOWN_WINNER_DISP_EN -- when defined, the DONE
// state shows the winner index instead of the frozen remaining digit.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   start     in   start/restart button (rising edge acts)
//   finish    in   [CH] per-channel finish buttons, level-sensitive
//   flag      out  a channel finished in time
//   winner    out  [3] lowest index among the finish bits that won
//   expired   out  countdown ran out
//   seg       out  [7] {g,f,e,d,c,b,a}, active-high
//   digit_en  out  digit select, constant 1
module countdown_arbiter #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int COUNT_FROM    = 5,
  parameter int CH            = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CH-1:0] finish,
  output logic          flag,
  output logic [2:0]    winner,
  output logic          expired,
  output logic [6:0]    seg,
  output logic          digit_en
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, EXPD} state_t;

  localparam logic [3:0]  DIG_INIT  = 4'(COUNT_FROM);
  localparam logic [31:0] PRESC_TOP = 32'(TICKS_PER_SEC - 1);
  localparam logic [6:0]  SEG_E     = 7'b1111001;

  state_t      state, state_nx;
  logic        start_q, start_rise;
  logic [31:0] presc, presc_nx;
  logic [3:0]  digit, digit_nx;
  logic        flag_nx, expired_nx;
  logic [2:0]  winner_nx, win_idx;
  logic [6:0]  seg_nx;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0111111;
      4'd1:    seg_code = 7'b0000110;
      4'd2:    seg_code = 7'b1011011;
      4'd3:    seg_code = 7'b1001111;
      4'd4:    seg_code = 7'b1100110;
      4'd5:    seg_code = 7'b1101101;
      4'd6:    seg_code = 7'b1111101;
      4'd7:    seg_code = 7'b0000111;
      4'd8:    seg_code = 7'b1111111;
      4'd9:    seg_code = 7'b1101111;
      default: seg_code = 7'b0000000;
    endcase
  endfunction

  assign start_rise = start & ~start_q;

  // Lowest set index wins: scan from the top so lower indices overwrite.
  always_comb begin
    win_idx = 3'd0;
    for (int i = CH - 1; i >= 0; i--)
      if (finish[i]) win_idx = 3'(i);
  end

  always_comb begin
    state_nx   = state;
    presc_nx   = presc;
    digit_nx   = digit;
    flag_nx    = flag;
    winner_nx  = winner;
    expired_nx = expired;

    if (start_rise) begin
      state_nx   = RUN;
      presc_nx   = '0;
      digit_nx   = DIG_INIT;
      flag_nx    = 1'b0;
      winner_nx  = 3'd0;
      expired_nx = 1'b0;
    end else if (state == RUN) begin
      // Finish beats expiry, so a press in the very last tick still wins.
      if (|finish) begin
        state_nx  = DONE;
        flag_nx   = 1'b1;
        winner_nx = win_idx;
      end else if (presc == PRESC_TOP) begin
        if (digit > 4'd1) begin
          presc_nx = '0;
          digit_nx = digit - 4'd1;
        end else begin
          state_nx   = EXPD;
          expired_nx = 1'b1;
        end
      end else begin
        presc_nx = presc + 32'd1;
      end
    end

    // Display is derived from the next state so seg is registered alongside it.
    case (state_nx)
      IDLE:    seg_nx = seg_code(DIG_INIT);
      RUN:     seg_nx = seg_code(digit_nx);
`ifdef COUNTDOWN_WINNER_DISP_EN
      DONE:    seg_nx = seg_code({1'b0, winner_nx});
`else
      DONE:    seg_nx = seg_code(digit_nx);
`endif
      default: seg_nx = SEG_E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      presc    <= '0;
      digit    <= DIG_INIT;
      flag     <= 1'b0;
      winner   <= 3'd0;
      expired  <= 1'b0;
      seg      <= seg_code(DIG_INIT);
      digit_en <= 1'b1;
    end else begin
      state    <= state_nx;
      start_q  <= start;
      presc    <= presc_nx;
      digit    <= digit_nx;
      flag     <= flag_nx;
      winner   <= winner_nx;
      expired  <= expired_nx;
      seg      <= seg_nx;
      digit_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_countdown_arbiter.sv
// tb_countdown_arbiter: directed scenarios plus randomized traffic, every
// cycle compared against a model that tracks elapsed RUN cycles.
module tb_countdown_arbiter;
  localparam int TPS = 10;
  localparam int CF  = 5;
  localparam int CH  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CH-1:0] finish = '0;
  logic          flag, expired, digit_en;
  logic [2:0]    winner;
  logic [6:0]    seg;

  int checks = 0;
  int passes = 0;

  // Model: 0 idle, 1 run, 2 done, 3 expired; m_el = cycles since RUN entry.
  int         m_st = 0, m_el = 0, m_frz = CF;
  logic       m_flag = 1'b0, m_exp = 1'b0, m_sq = 1'b0;
  logic [2:0] m_win = 3'd0;

  countdown_arbiter #(.TICKS_PER_SEC(TPS), .COUNT_FROM(CF), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .flag(flag), .winner(winner), .expired(expired), .seg(seg),
    .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] code(input int d);
    case (d)
      0: code = 7'b0111111;  1: code = 7'b0000110;  2: code = 7'b1011011;
      3: code = 7'b1001111;  4: code = 7'b1100110;  5: code = 7'b1101101;
      6: code = 7'b1111101;  7: code = 7'b0000111;  8: code = 7'b1111111;
      9: code = 7'b1101111;  default: code = 7'b1111001;  // E
    endcase
  endfunction

  // Expected {seg, flag, winner, expired, digit_en}.
  function automatic logic [12:0] exp_out();
    logic [6:0] s;
    case (m_st)
      0: s = code(CF);
      1: s = code(CF - m_el / TPS);
`ifdef COUNTDOWN_WINNER_DISP_EN
      2: s = code(int'(m_win));
`else
      2: s = code(m_frz);
`endif
      default: s = code(-1);
    endcase
    exp_out = {s, m_flag, m_win, m_exp, 1'b1};
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic rise;
    @(posedge clk);
    if (!rst_n) begin
      m_st = 0; m_el = 0; m_flag = 0; m_win = 0; m_exp = 0; m_sq = 0;
    end else begin
      rise = start & ~m_sq;
      m_sq = start;
      if (rise) begin
        m_st = 1; m_el = 0; m_flag = 0; m_win = 0; m_exp = 0;
      end else if (m_st == 1) begin
        if (finish != 0) begin
          m_st = 2; m_flag = 1; m_frz = CF - m_el / TPS;
          for (int i = CH - 1; i >= 0; i--) if (finish[i]) m_win = 3'(i);
        end else begin
          m_el++;
          if (m_el == CF * TPS) begin m_st = 3; m_exp = 1; end
        end
      end
    end
    #1;
  endtask

  task automatic run_entry();
    start = 1'b0; finish = '0; tick();
    start = 1'b1; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    checks++;
    if ({seg, flag, winner, expired, digit_en} !== {7'b1101101, 1'b0, 3'd0, 1'b0, 1'b1})
      $display("FAIL reset_state: got %b want %b", {seg, flag, winner, expired, digit_en},
               {7'b1101101, 1'b0, 3'd0, 1'b0, 1'b1});
    else passes++;
    rst_n = 1'b1; tick(); tick();
    checks++;
    if ({seg, flag, winner, expired, digit_en} !== exp_out())
      $display("FAIL idle_hold: got %b want %b", {seg, flag, winner, expired, digit_en}, exp_out());
    else passes++;
  endtask

  task automatic test_expiry();
    int bad = 0;
    run_entry();
    for (int k = 1; k <= 50; k++) begin
      if (seg !== code(CF - (k - 1) / TPS) || expired !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) $display("FAIL digit_walk: %0d bad cycles, want 0", bad);
    else passes++;
    checks++;
    if ({expired, seg, flag} !== {1'b1, 7'b1111001, 1'b0})
      $display("FAIL expiry_at_50: got %b want %b", {expired, seg, flag}, {1'b1, 7'b1111001, 1'b0});
    else passes++;
    finish = 4'b0001; tick(); tick();
    checks++;
    if ({expired, seg, flag, winner} !== {1'b1, 7'b1111001, 1'b0, 3'd0})
      $display("FAIL finish_after_expiry: got %b want %b", {expired, seg, flag, winner},
               {1'b1, 7'b1111001, 1'b0, 3'd0});
    else passes++;
    finish = '0;
  endtask

  task automatic test_finish_mid();
    logic [6:0] want;
    run_entry();
    for (int k = 0; k < 23; k++) tick();
    finish = 4'b1010; tick();
`ifdef COUNTDOWN_WINNER_DISP_EN
    want = 7'b0000110;
`else
    want = 7'b1001111;
`endif
    checks++;
    if ({flag, winner, expired, seg} !== {1'b1, 3'd1, 1'b0, want})
      $display("FAIL finish_mid: got %b want %b", {flag, winner, expired, seg}, {1'b1, 3'd1, 1'b0, want});
    else passes++;
    finish = '0; tick(); tick();
    checks++;
    if ({seg, flag, winner, expired, digit_en} !== exp_out())
      $display("FAIL done_hold: got %b want %b", {seg, flag, winner, expired, digit_en}, exp_out());
    else passes++;
  endtask

  task automatic test_last_cycle();
    run_entry();
    for (int k = 0; k < 49; k++) tick();
    finish = 4'b0100; tick();
    checks++;
    if ({flag, winner, expired} !== {1'b1, 3'd2, 1'b0})
      $display("FAIL last_cycle_finish: got %b want %b", {flag, winner, expired}, {1'b1, 3'd2, 1'b0});
    else passes++;
    checks++;
    if ({seg, flag, winner, expired, digit_en} !== exp_out())
      $display("FAIL last_cycle_seg: got %b want %b", {seg, flag, winner, expired, digit_en}, exp_out());
    else passes++;
    finish = '0;
  endtask

  task automatic test_restart_in_done();
    start = 1'b0; tick();
    start = 1'b1; finish = 4'b0001; tick();
    checks++;
    if ({flag, expired, seg} !== {1'b0, 1'b0, 7'b1101101})
      $display("FAIL restart_wins: got %b want %b", {flag, expired, seg}, {1'b0, 1'b0, 7'b1101101});
    else passes++;
    finish = '0; tick(); tick();
    checks++;
    if ({seg, flag, winner, expired, digit_en} !== exp_out())
      $display("FAIL running_after_restart: got %b want %b", {seg, flag, winner, expired, digit_en}, exp_out());
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    run_entry();
    for (int k = 0; k < 35; k++) tick();
    rst_n = 1'b0; start = 1'b0; tick();
    checks++;
    if ({seg, flag, winner, expired} !== {7'b1101101, 1'b0, 3'd0, 1'b0})
      $display("FAIL reset_mid_run: got %b want %b", {seg, flag, winner, expired}, {7'b1101101, 1'b0, 3'd0, 1'b0});
    else passes++;
    rst_n = 1'b1; tick();
    start = 1'b1; tick();
    for (int k = 0; k < 49; k++) tick();
    checks++;
    if ({expired, seg} !== {1'b0, 7'b0000110})
      $display("FAIL full_count_49: got %b want %b", {expired, seg}, {1'b0, 7'b0000110});
    else passes++;
    tick();
    checks++;
    if ({expired, seg} !== {1'b1, 7'b1111001})
      $display("FAIL full_count_50: got %b want %b", {expired, seg}, {1'b1, 7'b1111001});
    else passes++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 29) == 0) start = ~start;
      finish = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : '0;
      rst_n  = ($urandom_range(0, 299) != 0);
      tick();
      checks++;
      if ({seg, flag, winner, expired, digit_en} !== exp_out()) begin
        if (bad < 10)
          $display("FAIL random_cycle_%0d: got %b want %b", n, {seg, flag, winner, expired, digit_en}, exp_out());
        bad++;
      end else passes++;
    end
    rst_n = 1'b1; finish = '0;
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_finish_mid();
    test_last_cycle();
    test_restart_in_done();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
